// File: rtl/ball_ctrl.sv
// Pong ball motion controller: serve timing, per-frame motion,
// wall and paddle bounces, and miss detection with score pulses.
module ball_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int PADDLE_L_X   = 20,
    parameter int PADDLE_R_X   = 620,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic [8:0] pl_y,
    input  logic [8:0] pr_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       serving,
    output logic       score_l,
    output logic       score_r
);

    localparam logic [1:0] SERVE  = 2'd0;
    localparam logic [1:0] MOVE   = 2'd1;
    localparam logic [1:0] SCORED = 2'd2;

    localparam int HALF = BALL_SIZE >> 1;
    localparam int PW_2 = PADDLE_W >> 1;
    localparam int PH_2 = PADDLE_H >> 1;
    localparam int CW   = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0] STEP   = 11'(HALF + SPEED);
    localparam logic [10:0] L_FACE = 11'(PADDLE_L_X + PW_2);
    localparam logic [10:0] R_FACE = 11'(PADDLE_R_X - PW_2);
    localparam logic [10:0] REACH  = 11'(PH_2 + HALF);
    localparam logic [10:0] X_MAX  = 11'(H_RES - 1);
    localparam logic [10:0] Y_LIM  = 11'(V_RES);

    localparam logic [9:0] X_CTR  = 10'(H_RES / 2);
    localparam logic [9:0] X_LBNC = 10'(PADDLE_L_X + PW_2 + HALF + 1);
    localparam logic [9:0] X_RBNC = 10'(PADDLE_R_X - PW_2 - HALF - 1);
    localparam logic [9:0] DX     = 10'(SPEED);
    localparam logic [8:0] Y_CTR  = 9'(V_RES / 2);
    localparam logic [8:0] Y_TOP  = 9'(HALF);
    localparam logic [8:0] Y_BOT  = 9'(V_RES - 1 - HALF);
    localparam logic [8:0] DY     = 9'(SPEED);

    localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_FRAMES);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          dx;
    logic          dy;

    logic [10:0] x11, y11, pl11, pr11;
    logic        near_l, near_r;
    logic        hit_l, hit_r;
    logic        miss_l, miss_r;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        ndx, ndy;

    // Widen everything so the edge tests never wrap below zero.
    assign x11  = {1'b0, ball_x};
    assign y11  = {2'b0, ball_y};
    assign pl11 = {2'b0, pl_y};
    assign pr11 = {2'b0, pr_y};

    assign near_l = (y11 < pl11 + REACH) && (pl11 < y11 + REACH);
    assign near_r = (y11 < pr11 + REACH) && (pr11 < y11 + REACH);

    assign hit_l = !dx && (x11 <= L_FACE + STEP) && (x11 > L_FACE) && near_l;
    assign hit_r = dx && (x11 + STEP >= R_FACE) && (x11 < R_FACE) && near_r;

    assign serving = (state == SERVE);

    always_comb begin
        nx     = ball_x;
        ndx    = dx;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (hit_l) begin
            nx  = X_LBNC;
            ndx = 1'b1;
        end else if (hit_r) begin
            nx  = X_RBNC;
            ndx = 1'b0;
        end else if (!dx && x11 <= STEP) begin
            miss_l = 1'b1;
        end else if (dx && x11 + STEP >= X_MAX) begin
            miss_r = 1'b1;
        end else begin
            nx = dx ? ball_x + DX : ball_x - DX;
        end
    end

    always_comb begin
        ny  = ball_y;
        ndy = dy;
        if (!dy && y11 < STEP) begin
            ny  = Y_TOP;
            ndy = 1'b1;
        end else if (dy && y11 + STEP >= Y_LIM) begin
            ny  = Y_BOT;
            ndy = 1'b0;
        end else begin
            ny = dy ? ball_y + DY : ball_y - DY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SERVE;
            cnt     <= CNT_INIT;
            ball_x  <= X_CTR;
            ball_y  <= Y_CTR;
            dx      <= 1'b1;
            dy      <= 1'b1;
            score_l <= 1'b0;
            score_r <= 1'b0;
        end else begin
            score_l <= 1'b0;
            score_r <= 1'b0;
            case (state)
                SERVE: begin
                    if (frame) begin
                        if (cnt == '0) state <= MOVE;
                        else           cnt   <= cnt - CW'(1);
                    end
                end
                MOVE: begin
                    if (frame) begin
                        ball_x <= nx;
                        ball_y <= ny;
                        dx     <= ndx;
                        dy     <= ndy;
                        // A miss holds x so the loser's side is visible for one cycle.
                        if (miss_l || miss_r) begin
                            state   <= SCORED;
                            score_r <= miss_l;
                            score_l <= miss_r;
                        end
                    end
                end
                SCORED: begin
                    cnt    <= CNT_INIT;
                    ball_x <= X_CTR;
                    ball_y <= Y_CTR;
                    state  <= SERVE;
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: a behavioural game model feeds a
// scoreboard of expected outputs, compared when the DUT updates.
module tb_ball_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic [8:0] pl_y;
    logic [8:0] pr_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       serving;
    logic       score_l;
    logic       score_r;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int   x;
        int   y;
        logic sv;
        logic sl;
        logic sr;
    } exp_t;

    exp_t q[$];

    int m_x, m_y, m_cnt, m_st;
    bit m_dx, m_dy;
    bit last_sl, last_sr;

    ball_ctrl dut (
        .clk(clk),
        .rst(rst),
        .frame(frame),
        .pl_y(pl_y),
        .pr_y(pr_y),
        .ball_x(ball_x),
        .ball_y(ball_y),
        .serving(serving),
        .score_l(score_l),
        .score_r(score_r)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_x   = 320;
        m_y   = 240;
        m_cnt = 60;
        m_st  = 0;
        m_dx  = 1'b1;
        m_dy  = 1'b1;
        q.delete();
    endtask

    // Game rules in signed integer form, independent of the RTL's widths.
    task automatic model_frame(input int pl, input int pr);
        int nx, ny;
        exp_t e;
        last_sl = 1'b0;
        last_sr = 1'b0;
        if (m_st == 0) begin
            if (m_cnt == 0) m_st = 1;
            else            m_cnt--;
        end else begin
            nx = m_x;
            ny = m_y;
            if (!m_dx && m_x - 7 <= 25 && m_x > 25 && iabs(m_y - pl) < 35) begin
                nx = 31; m_dx = 1'b1;
            end else if (m_dx && m_x + 7 >= 615 && m_x < 615 && iabs(m_y - pr) < 35) begin
                nx = 609; m_dx = 1'b0;
            end else if (!m_dx && m_x - 5 <= 2) begin
                last_sr = 1'b1;
            end else if (m_dx && m_x + 7 >= 639) begin
                last_sl = 1'b1;
            end else begin
                nx = m_dx ? m_x + 2 : m_x - 2;
            end
            if (!m_dy && m_y < 7) begin
                ny = 5; m_dy = 1'b1;
            end else if (m_dy && m_y + 7 >= 480) begin
                ny = 474; m_dy = 1'b0;
            end else begin
                ny = m_dy ? m_y + 2 : m_y - 2;
            end
            m_x = nx;
            m_y = ny;
        end
        e = '{x: m_x, y: m_y, sv: (m_st == 0), sl: last_sl, sr: last_sr};
        q.push_back(e);
        if (last_sl || last_sr) begin
            m_st = 0; m_cnt = 60; m_x = 320; m_y = 240;
            e = '{x: 320, y: 240, sv: 1'b1, sl: 1'b0, sr: 1'b0};
            q.push_back(e);
        end
    endtask

    // Drive one frame pulse, then compare every queued expectation.
    task automatic sb_frame(input int pl, input int pr, input int idle);
        exp_t e;
        @(negedge clk);
        pl_y  = 9'(pl);
        pr_y  = 9'(pr);
        frame = 1'b1;
        model_frame(pl, pr);
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            frame = 1'b0;
            e = q.pop_front();
            tests_run++;
            if (ball_x !== 10'(e.x) || ball_y !== 9'(e.y) || serving !== e.sv ||
                score_l !== e.sl || score_r !== e.sr) begin
                tests_failed++;
                $display("FAIL sb_frame: got x=%0d y=%0d sv=%b sl=%b sr=%b want x=%0d y=%0d sv=%b sl=%b sr=%b",
                         ball_x, ball_y, serving, score_l, score_r,
                         e.x, e.y, e.sv, e.sl, e.sr);
            end
        end
        repeat (idle) @(posedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        frame = 1'b0;
        pl_y  = 9'd240;
        pr_y  = 9'd240;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (ball_x !== 10'd320 || ball_y !== 9'd240 || serving !== 1'b1 ||
            score_l !== 1'b0 || score_r !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got x=%0d y=%0d sv=%b sl=%b sr=%b want 320 240 1 0 0",
                     ball_x, ball_y, serving, score_l, score_r);
        end
    endtask

    task automatic test_serve();
        for (int i = 0; i < 60; i++) begin
            sb_frame(240, 240, 2);
            tests_run++;
            if (serving !== 1'b1 || ball_x !== 10'd320 || ball_y !== 9'd240) begin
                tests_failed++;
                $display("FAIL serve_hold[%0d]: got sv=%b x=%0d y=%0d want 1 320 240",
                         i, serving, ball_x, ball_y);
            end
        end
        sb_frame(240, 240, 2);
        tests_run++;
        if (serving !== 1'b0 || ball_x !== 10'd320 || ball_y !== 9'd240) begin
            tests_failed++;
            $display("FAIL serve_release: got sv=%b x=%0d y=%0d want 0 320 240",
                     serving, ball_x, ball_y);
        end
        sb_frame(240, 240, 2);
        tests_run++;
        if (ball_x !== 10'd322 || ball_y !== 9'd242) begin
            tests_failed++;
            $display("FAIL first_move: got x=%0d y=%0d want 322 242", ball_x, ball_y);
        end
    endtask

    // Paddles track the ball: paddle and wall bounces, no misses.
    task automatic test_rally();
        for (int i = 0; i < 700; i++) begin
            sb_frame(m_y, m_y, 3);
            tests_run++;
            if (score_l !== 1'b0 || score_r !== 1'b0) begin
                tests_failed++;
                $display("FAIL rally_no_score[%0d]: got sl=%b sr=%b want 0 0",
                         i, score_l, score_r);
            end
        end
    endtask

    // Paddles kept away from the ball until someone misses.
    task automatic test_miss();
        bit hit;
        bit left_missed;
        int px;
        hit = 1'b0;
        left_missed = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            px = (m_y < 240) ? 470 : 10;
            sb_frame(px, px, 1);
            if (last_sl || last_sr) begin
                hit = 1'b1;
                left_missed = last_sr;
            end
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL miss_timeout: got no score within 400 frames want a score");
        end
        for (int i = 0; i < 61; i++) sb_frame(240, 240, 1);
        sb_frame(240, 240, 1);
        tests_run++;
        if (ball_x !== (left_missed ? 10'd318 : 10'd322)) begin
            tests_failed++;
            $display("FAIL serve_to_loser: got x=%0d want %0d",
                     ball_x, left_missed ? 318 : 322);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 20; i++) sb_frame(m_y, m_y, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (ball_x !== 10'd320 || ball_y !== 9'd240 || serving !== 1'b1 ||
            score_l !== 1'b0 || score_r !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got x=%0d y=%0d sv=%b sl=%b sr=%b want 320 240 1 0 0",
                     ball_x, ball_y, serving, score_l, score_r);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 62; i++) sb_frame(240, 240, 1);
        tests_run++;
        if (ball_x !== 10'd322 || ball_y !== 9'd242) begin
            tests_failed++;
            $display("FAIL post_reset_move: got x=%0d y=%0d want 322 242", ball_x, ball_y);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_rally();
        test_miss();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
